greater_bist: RTL

Self-checking stimulus/response engine for the two-operand `greater` comparator. On `start` it sweeps every `{A, B}` combination in ascending order and holds each vector for a fixed number of cycles. On the last cycle of each hold it samples the comparator output and checks it against the expected `A > B`. At the end of the sweep it reports a pass flag, an error count and the first failing vector. It sits next to a `greater` instance in synthesizable self-test designs, as the hardware counterpart to the exhaustive bench sweep.

---
 rtl/greater_bist.sv | 106 ++++++++++
 1 files changed

// File: rtl/greater_bist.sv
// Exhaustive stimulus/response engine for a two-operand `greater` comparator.
// Optional macro GREATER_BIST_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module greater_bist #(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               f_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [2*WIDTH-1:0] first_fail_vec
);

    // state | meaning
    // IDLE  | reset state, waiting for start
    // RUN   | sweeping vectors, checking f_in on the last hold cycle
    // DONE  | results held until the next start
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int VW = 2 * WIDTH;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [VW-1:0] VEC_LAST  = '1;

    state_t        state, state_nxt;
    logic [VW-1:0] vec, vec_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [VW:0]   err, err_nxt;
    logic [VW-1:0] ffv, ffv_nxt;
    logic          check, expected, mismatch;

    assign check    = (state == RUN) && (hold_cnt == HOLD_LAST);
    assign expected = vec[VW-1:WIDTH] > vec[WIDTH-1:0];
    assign mismatch = check && (f_in != expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vec      <= '0;
            hold_cnt <= '0;
            err      <= '0;
            ffv      <= '0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            hold_cnt <= hold_nxt;
            err      <= err_nxt;
            ffv      <= ffv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        hold_nxt  = hold_cnt;
        err_nxt   = err;
        ffv_nxt   = ffv;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    vec_nxt   = '0;
                    hold_nxt  = '0;
                    err_nxt   = '0;
                    ffv_nxt   = '0;
                end
            end
            RUN: begin
                if (!check) begin
                    hold_nxt = hold_cnt + HW'(1);
                end else begin
                    if (mismatch) begin
                        err_nxt = err + (VW+1)'(1);
                        if (err == '0) ffv_nxt = vec;
                    end
`ifdef GREATER_BIST_STOP_ON_FAIL_EN
                    if (mismatch || vec == VEC_LAST) begin
`else
                    if (vec == VEC_LAST) begin
`endif
                        state_nxt = DONE;
                    end else begin
                        vec_nxt  = vec + VW'(1);
                        hold_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign a_out          = vec[VW-1:WIDTH];
    assign b_out          = vec[WIDTH-1:0];
    assign busy           = (state == RUN);
    assign done           = (state == DONE);
    assign pass           = (state == DONE) && (err == '0);
    assign err_count      = err;
    assign first_fail_vec = ffv;

endmodule
